// File: rtl/case_3_sdiv_13s_8s_seq.sv
// Sequential signed divider: 13-bit signed dividend / 8-bit signed divisor -> 13-bit quotient, 8-bit remainder.
// Latency: start accepted in cycle T, ap_done/ap_ready pulse in cycle T+N+2 (T+15 for N=13); one op per N+3 cycles.
// Backpressure: none; ap_start is only sampled in IDLE, so requests made while busy are simply ignored.
//
// Ports:
//   ap_clk    - clock, all logic on the rising edge
//   ap_rst    - synchronous active-high reset; aborts any operation and zeroes the result outputs
//   ap_start  - request, sampled only while idle; din0/din1 are captured in the same cycle
//   ap_ready  - one-cycle pulse when the result is presented (coincides with ap_done)
//   ap_done   - one-cycle pulse when the result is presented
//   ap_idle   - high while the divider can accept a request
//   din0      - signed dividend
//   din1      - signed divisor
//   quot      - signed quotient, truncated toward zero; held until the next operation's FIX step
//   rem       - signed remainder, sign follows the dividend; held like quot
//   div_zero  - high when the held result came from a zero divisor
//
// The core is a radix-2 restoring divider working on magnitudes. The signs are
// remembered at accept time and applied in a single FIX cycle at the end, so the
// iteration loop itself only ever sees non-negative numbers.

module case_3_sdiv_13s_8s_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 13,
    parameter int din1_WIDTH = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic                  ap_idle,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [din0_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  div_zero
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int W0 = din0_WIDTH;          // dividend / quotient width
    localparam int W1 = din1_WIDTH;          // divisor / remainder width
    localparam int PW = din1_WIDTH + 1;      // partial remainder width
    localparam int N  = din0_WIDTH;          // one quotient bit per iteration
    localparam int CW = $clog2(N + 1);       // iteration counter width

    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Operand magnitudes
    // Both are formed one bit wider than the operand so that the most
    // negative value (-4096, -128) has an exact positive magnitude.
    // ------------------------------------------------------------------
    logic [W0:0] din0_ext;
    logic [W0:0] din0_mag;
    logic [W1:0] din1_ext;
    logic [W1:0] din1_mag;

    assign din0_ext = {din0[W0-1], din0};
    assign din1_ext = {din1[W1-1], din1};
    assign din0_mag = din0_ext[W0] ? -din0_ext : din0_ext;
    assign din1_mag = din1_ext[W1] ? -din1_ext : din1_ext;

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [W0:0]   dvd;        // dividend magnitude, consumed MSB first
    logic [PW-1:0] dsr;        // divisor magnitude
    logic [PW-1:0] part;       // partial remainder
    logic [W0-1:0] qacc;       // quotient magnitude, built LSB-in
    logic [CW-1:0] cnt;        // iterations completed
    logic          sign_q;     // quotient is negative
    logic          sign_r;     // remainder is negative (dividend sign)
    logic          zero;       // divisor was zero
    logic [W1-1:0] zrem;       // raw dividend low bits, returned as rem on /0

    logic [PW-1:0] shifted;    // partial remainder after bringing in next bit
    logic          geq;        // trial subtraction succeeds

    // The partial remainder entering an iteration is always below the divisor
    // magnitude (at most 128), so dropping its top bit before the shift loses
    // nothing. With a zero divisor every trial succeeds and the quotient fills
    // with ones; that value is overridden in FIX anyway.
    assign shifted = {part[W1-1:0], dvd[W0-1]};
    assign geq     = (shifted >= dsr);

    // ------------------------------------------------------------------
    // Control and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= IDLE;
            ap_idle  <= 1'b1;
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
            dvd      <= '0;
            dsr      <= '0;
            part     <= '0;
            qacc     <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            zero     <= 1'b0;
            zrem     <= '0;
        end else begin
            // Completion strobes are single-cycle unless FIX re-arms them.
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (ap_start) begin
                        dvd     <= din0_mag;
                        dsr     <= din1_mag;
                        sign_q  <= din0[W0-1] ^ din1[W1-1];
                        sign_r  <= din0[W0-1];
                        zero    <= (din1 == '0);
                        zrem    <= din0[W1-1:0];
                        part    <= '0;
                        qacc    <= '0;
                        cnt     <= '0;
                        ap_idle <= 1'b0;
                        state   <= CALC;
                    end
                end

                CALC: begin
                    // Restoring step: subtract only if the trial stays non-negative.
                    part <= geq ? (shifted - dsr) : shifted;
                    qacc <= {qacc[W0-2:0], geq};
                    dvd  <= dvd << 1;
                    cnt  <= cnt + CNT_ONE;
                    if (cnt == LAST_ITER) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    // Two's-complement negation truncated to the port width.
                    // A +4096 quotient magnitude (from -4096 / -1) therefore
                    // wraps to 0x1000 without any flag.
                    if (zero) begin
                        quot <= '1;
                        rem  <= zrem;
                    end else begin
                        quot <= sign_q ? -qacc : qacc;
                        rem  <= W1'(sign_r ? -part : part);
                    end
                    div_zero <= zero;
                    ap_done  <= 1'b1;
                    ap_ready <= 1'b1;
                    state    <= DONE;
                end

                DONE: begin
                    ap_idle <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    ap_idle <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_case_3_sdiv_13s_8s_seq.sv
// Testbench for the sequential signed divider.
// Latency: checks done at T+15 relative to the accept cycle.
// Backpressure: exercises held and ignored ap_start.

module tb_case_3_sdiv_13s_8s_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_idle;
    logic [12:0] din0;
    logic [7:0]  din1;
    logic [12:0] quot;
    logic [7:0]  rem;
    logic        div_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 ap_clk = ~ap_clk;

    case_3_sdiv_13s_8s_seq #(
        .ID(1),
        .din0_WIDTH(13),
        .din1_WIDTH(8)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .ap_start(ap_start),
        .ap_ready(ap_ready),
        .ap_done(ap_done),
        .ap_idle(ap_idle),
        .din0(din0),
        .din1(din1),
        .quot(quot),
        .rem(rem),
        .div_zero(div_zero)
    );

    // Advance to just after the next rising edge; outputs are sampled here.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Reference: plain integer division (truncates toward zero, remainder
    // follows the dividend), with the divide-by-zero convention on top.
    function automatic void ref_div(input logic [12:0] a, input logic [7:0] b,
                                    output logic [12:0] q, output logic [7:0] r,
                                    output logic dz);
        int ai, bi, qi, ri;
        ai = $signed(a);
        bi = $signed(b);
        if (bi == 0) begin
            q  = 13'h1FFF;
            r  = a[7:0];
            dz = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            q  = qi[12:0];
            r  = ri[7:0];
            dz = 1'b0;
        end
    endfunction

    // Issue one single-cycle start from an idle DUT and observe 18 cycles.
    // Returns the cycle offset of ap_done, how many done pulses were seen,
    // whether ap_idle was ever high during T+1..T+15, whether ap_ready ever
    // differed from ap_done, and the outputs captured at the done pulse.
    task automatic run_op(input logic [12:0] a, input logic [7:0] b,
                          output int lat, output int ndone, output bit idle_bad,
                          output bit rdy_bad, output logic [12:0] q,
                          output logic [7:0] r, output logic dz);
        lat      = -1;
        ndone    = 0;
        idle_bad = 1'b0;
        rdy_bad  = 1'b0;
        q        = '0;
        r        = '0;
        dz       = 1'b0;
        ap_start = 1'b1;
        din0     = a;
        din1     = b;
        tick();
        ap_start = 1'b0;
        din0     = 13'($urandom);
        din1     = 8'($urandom);
        for (int k = 1; k <= 18; k++) begin
            if (ap_done === 1'b1) begin
                ndone++;
                lat = k;
                q   = quot;
                r   = rem;
                dz  = div_zero;
            end
            if (ap_ready !== ap_done) rdy_bad = 1'b1;
            if (k <= 15 && ap_idle !== 1'b0) idle_bad = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        ap_rst   = 1'b1;
        ap_start = 1'b1;
        din0     = 13'd5;
        din1     = 8'd1;
        tick();
        tick();
        tick();
        n_vec++;
        if ({ap_idle, ap_done, ap_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_ctrl: idle/done/ready=%b expected 100", {ap_idle, ap_done, ap_ready});
        end
        n_vec++;
        if ({quot, rem, div_zero} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_data: quot=%h rem=%h dz=%b expected all zero", quot, rem, div_zero);
        end
        // start was high in the last reset cycle; it must not have been taken
        ap_rst   = 1'b0;
        ap_start = 1'b0;
        tick();
        n_vec++;
        if (ap_idle !== 1'b1) begin
            n_err++;
            $display("FAIL reset_start_ignored: ap_idle=%b expected 1", ap_idle);
        end
    endtask

    task automatic test_basic();
        int lat, nd;
        bit ib, rb;
        logic [12:0] q;
        logic [7:0] r;
        logic dz;
        run_op(13'd100, 8'd7, lat, nd, ib, rb, q, r, dz);
        n_vec++;
        if (lat != 15 || nd != 1) begin
            n_err++;
            $display("FAIL basic_latency: done at T+%0d count %0d, expected T+15 count 1", lat, nd);
        end
        n_vec++;
        if (q !== 13'd14 || r !== 8'd2 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: q=%0d r=%0d dz=%b expected 14 2 0", $signed(q), $signed(r), dz);
        end
        n_vec++;
        if (rb) begin
            n_err++;
            $display("FAIL basic_ready: ap_ready differed from ap_done, expected equal");
        end
        n_vec++;
        if (quot !== 13'd14 || rem !== 8'd2) begin
            n_err++;
            $display("FAIL basic_hold: quot=%0d rem=%0d in idle, expected 14 2", $signed(quot), $signed(rem));
        end
    endtask

    task automatic test_signs();
        int ta[4] = '{100, -100, 100, -100};
        int tb[4] = '{7, 7, -7, -7};
        int tq[4] = '{14, -14, -14, 14};
        int tr[4] = '{2, -2, 2, -2};
        int lat, nd;
        bit ib, rb;
        logic [12:0] q;
        logic [7:0] r;
        logic dz;
        for (int i = 0; i < 4; i++) begin
            run_op(13'(ta[i]), 8'(tb[i]), lat, nd, ib, rb, q, r, dz);
            n_vec++;
            if (lat != 15 || nd != 1 || ib) begin
                n_err++;
                $display("FAIL signs_timing[%0d]: done T+%0d count %0d idle_bad %0d, expected T+15 1 0", i, lat, nd, ib);
            end
            n_vec++;
            if (q !== 13'(tq[i]) || r !== 8'(tr[i]) || dz !== 1'b0) begin
                n_err++;
                $display("FAIL signs_result[%0d]: %0d/%0d gave q=%0d r=%0d expected %0d %0d",
                         i, ta[i], tb[i], $signed(q), $signed(r), tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_extremes();
        int ta[4] = '{-4096, -4096, 4095, 4095};
        int tb[4] = '{-1, -128, 1, -128};
        int tq[4] = '{-4096, 32, 4095, -31};
        int tr[4] = '{0, 0, 0, 127};
        int lat, nd;
        bit ib, rb;
        logic [12:0] q;
        logic [7:0] r;
        logic dz;
        for (int i = 0; i < 4; i++) begin
            run_op(13'(ta[i]), 8'(tb[i]), lat, nd, ib, rb, q, r, dz);
            n_vec++;
            if (lat != 15 || q !== 13'(tq[i]) || r !== 8'(tr[i]) || dz !== 1'b0) begin
                n_err++;
                $display("FAIL extreme[%0d]: %0d/%0d gave T+%0d q=%0d r=%0d dz=%b expected T+15 %0d %0d 0",
                         i, ta[i], tb[i], lat, $signed(q), $signed(r), dz, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, nd;
        bit ib, rb;
        logic [12:0] q;
        logic [7:0] r;
        logic dz;
        run_op(13'h0A5, 8'd0, lat, nd, ib, rb, q, r, dz);
        n_vec++;
        if (lat != 15 || nd != 1) begin
            n_err++;
            $display("FAIL divzero_latency: done T+%0d count %0d expected T+15 1", lat, nd);
        end
        n_vec++;
        if (q !== 13'h1FFF || r !== 8'hA5 || dz !== 1'b1) begin
            n_err++;
            $display("FAIL divzero_result: q=%h r=%h dz=%b expected 1fff a5 1", q, r, dz);
        end
        run_op(13'd9, 8'd3, lat, nd, ib, rb, q, r, dz);
        n_vec++;
        if (q !== 13'd3 || r !== 8'd0 || dz !== 1'b0) begin
            n_err++;
            $display("FAIL divzero_recover: q=%0d r=%0d dz=%b expected 3 0 0", $signed(q), $signed(r), dz);
        end
    endtask

    task automatic test_held_start();
        int          done_k[$];
        logic [12:0] done_q[$];
        logic        idle16;
        idle16   = 1'b0;
        ap_start = 1'b1;
        din0     = 13'd50;
        din1     = 8'd5;
        tick();
        for (int k = 1; k <= 34; k++) begin
            if (k == 3) begin
                din0 = 13'd60;
                din1 = 8'd5;
            end
            if (k == 16) idle16 = ap_idle;
            if (k == 17) ap_start = 1'b0;
            if (ap_done === 1'b1) begin
                done_k.push_back(k);
                done_q.push_back(quot);
            end
            tick();
        end
        n_vec++;
        if (done_k.size() != 2) begin
            n_err++;
            $display("FAIL held_count: %0d done pulses expected 2", done_k.size());
        end else begin
            n_vec++;
            if (done_k[0] != 15 || done_q[0] !== 13'd10) begin
                n_err++;
                $display("FAIL held_first: T+%0d q=%0d expected T+15 10", done_k[0], $signed(done_q[0]));
            end
            n_vec++;
            if (done_k[1] != 31 || done_q[1] !== 13'd12) begin
                n_err++;
                $display("FAIL held_second: T+%0d q=%0d expected T+31 12", done_k[1], $signed(done_q[1]));
            end
        end
        n_vec++;
        if (idle16 !== 1'b1) begin
            n_err++;
            $display("FAIL held_idle16: ap_idle=%b at T+16 expected 1", idle16);
        end
    endtask

    task automatic test_ignored_start();
        int          nd;
        int          lat;
        logic [12:0] q;
        nd       = 0;
        lat      = -1;
        q        = '0;
        ap_start = 1'b1;
        din0     = 13'd20;
        din1     = 8'd3;
        tick();
        for (int k = 1; k <= 22; k++) begin
            if (ap_done === 1'b1) begin
                nd++;
                lat = k;
                q   = quot;
            end
            ap_start = (k == 3 || k == 7 || k == 12 || k == 14 || k == 15);
            din0     = 13'($urandom);
            din1     = 8'($urandom);
            tick();
        end
        ap_start = 1'b0;
        n_vec++;
        if (nd != 1 || lat != 15 || q !== 13'd6) begin
            n_err++;
            $display("FAIL ignored_start: %0d done pulses, last T+%0d q=%0d expected 1 T+15 6", nd, lat, $signed(q));
        end
        n_vec++;
        if (ap_idle !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_idle: ap_idle=%b expected 1", ap_idle);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nd;
        bit ib, rb;
        logic [12:0] q, eq;
        logic [7:0] r, er;
        logic dz, edz;
        nd       = 0;
        ap_start = 1'b1;
        din0     = 13'd77;
        din1     = 8'd5;
        tick();
        ap_start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (ap_done === 1'b1) nd++;
            if (k == 6) ap_rst = 1'b1;
            tick();
        end
        ap_rst = 1'b0;
        n_vec++;
        if (nd != 0 || ap_done !== 1'b0 || ap_idle !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_ctrl: done pulses %0d done=%b idle=%b expected 0 0 1", nd, ap_done, ap_idle);
        end
        n_vec++;
        if (quot !== 13'd0 || rem !== 8'd0 || div_zero !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_data: quot=%h rem=%h dz=%b expected 0 0 0", quot, rem, div_zero);
        end
        tick();
        run_op(13'd77, -8'sd5, lat, nd, ib, rb, q, r, dz);
        ref_div(13'd77, -8'sd5, eq, er, edz);
        n_vec++;
        if (lat != 15 || nd != 1 || q !== eq || r !== er || dz !== edz) begin
            n_err++;
            $display("FAIL rstmid_restart: T+%0d n=%0d q=%0d r=%0d expected T+15 1 %0d %0d",
                     lat, nd, $signed(q), $signed(r), $signed(eq), $signed(er));
        end
    endtask

    task automatic test_random();
        int lat, nd;
        bit ib, rb;
        logic [12:0] a, q, eq;
        logic [7:0] b, r, er;
        logic dz, edz;
        for (int i = 0; i < 60; i++) begin
            a = 13'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) a = 13'h1000;
            if ($urandom_range(0, 7) == 0) b = 8'h80;
            if ($urandom_range(0, 9) == 0) b = 8'h00;
            ref_div(a, b, eq, er, edz);
            run_op(a, b, lat, nd, ib, rb, q, r, dz);
            n_vec++;
            if (lat != 15 || nd != 1 || ib || rb || q !== eq || r !== er || dz !== edz) begin
                n_err++;
                $display("FAIL random[%0d]: %0d/%0d got T+%0d n=%0d q=%0d r=%0d dz=%b expected T+15 1 %0d %0d %b",
                         i, $signed(a), $signed(b), lat, nd, $signed(q), $signed(r), dz,
                         $signed(eq), $signed(er), edz);
            end
        end
    endtask

    initial begin
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;
        test_reset();
        test_basic();
        test_signs();
        test_extremes();
        test_div_zero();
        test_held_start();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/case_3_sdiv_13s_8s_seq.md
# case_3_sdiv_13s_8s_seq

Sequential signed integer divider for the case_3 datapath. It is the inverse of the 9s×8s→13 product stage: it takes a 13-bit signed product-domain value and an 8-bit signed factor, and recovers the 13-bit quotient and the 8-bit remainder. It uses a radix-2 restoring algorithm on magnitudes, one quotient bit per cycle, with an ap_start/ap_done block-level handshake. The schedule instantiates it wherever a product must be un-scaled, and one instance serves a single operation at a time.

## Interface
Parameters:
- ID, 1: instance tag; no functional effect.
- din0_WIDTH, 13: dividend width, signed; sets the iteration count N.
- din1_WIDTH, 8: divisor width, signed; also the remainder width.

Ports:
- ap_clk  in  1  sole clock; all logic is on the rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- ap_start  in  1  request; sampled only in IDLE.
- ap_ready  out  1  one-cycle pulse; operands consumed and result available.
- ap_done  out  1  one-cycle pulse, coincident with ap_ready.
- ap_idle  out  1  high while in IDLE.
- din0  in  din0_WIDTH  dividend, signed; captured on the accept cycle.
- din1  in  din1_WIDTH  divisor, signed; captured on the accept cycle.
- quot  out  din0_WIDTH  quotient, signed, truncated toward zero.
- rem  out  din1_WIDTH  remainder, signed; takes the sign of the dividend.
- div_zero  out  1  high when the held result came from din1 == 0.

## Operation
States: IDLE, CALC, FIX, DONE.

- **IDLE**
  - ap_idle = 1.
  - If ap_start = 1:
    - latch |din0|, |din1|, sign_q = din0[msb] ^ din1[msb], sign_r = din0[msb], and zero = (din1 == 0);
    - clear the partial remainder and the counter;
    - go to CALC.
- **CALC** (exactly N = din0_WIDTH cycles)
  - Shift the partial remainder left and bring in the next dividend MSB.
  - If partial ≥ |divisor|: subtract it and shift in quotient bit 1; otherwise shift in 0.
  - After the N-th iteration, go to FIX.
- **FIX**
  - Apply the signs: quot = sign_q ? −q : q, and rem = sign_r ? −r : r.
  - Both use two's-complement negation, truncated to the port width.
  - Register quot, rem and div_zero.
  - Go to DONE.
- **DONE**
  - Assert ap_done = ap_ready = 1 for this one cycle.
  - Go to IDLE.

Arithmetic rules:
- Magnitudes are computed one bit wider than each operand, so |−4096| and |−128| are exact.
- The partial remainder is din1_WIDTH+1 bits wide.
- Overflow case −4096 / −1: the true quotient +4096 wraps to −4096 (0x1000), and rem = 0. No flag is raised.
- Divide by zero: quot = all ones (−1), rem = din0[din1_WIDTH−1:0], div_zero = 1. The cycle count is unchanged.
- |rem| ≤ 127 always, so rem never overflows.

Output holding:
- quot, rem and div_zero hold their values from the DONE cycle until the next FIX.
- They are not cleared on return to IDLE.

## Timing
Latency:
- Let T be the cycle with IDLE and ap_start = 1.
- CALC occupies T+1 … T+N, FIX is at T+N+1, and DONE is at T+N+2.
- With the default N = 13, ap_done is high at T+15.
- Outputs are valid from T+15 onward.

Handshake:
- ap_start is ignored outside IDLE.
- din0/din1 changes after T have no effect.
- If ap_start is held high, the next accept is at T+16 (throughput of one operation per N+3 cycles).

Reset:
- While ap_rst = 1, the FSM goes to IDLE.
- Output values during reset: quot = 0, rem = 0, div_zero = 0, ap_done = 0, ap_ready = 0, ap_idle = 1.
- Reset mid-operation aborts the operation: no ap_done is produced and the outputs are zeroed.
- ap_start in the same cycle as ap_rst is ignored.

## Test plan
- **Basic positive:** din0 = 100, din1 = 7, one-cycle start at T → ap_done at T+15 only; quot = 14, rem = 2, div_zero = 0.
- **Sign combinations:** check all four operand signs; ap_idle must be 0 from T+1 through T+15.

  | din0 | din1 | quot | rem |
  |------|------|------|-----|
  | −100 | 7 | −14 | −2 |
  | 100 | −7 | −14 | 2 |
  | −100 | −7 | 14 | −2 |

- **Extremes:**
  - −4096 / −1 → quot = −4096, rem = 0.
  - −4096 / −128 → quot = 32, rem = 0.
  - 4095 / 1 → quot = 4095, rem = 0.
  - 4095 / −128 → quot = −31, rem = 127.
- **Divide by zero:** din0 = 0x0A5, din1 = 0 → quot = 0x1FFF, rem = 0xA5, div_zero = 1, still at T+15. The following 9 / 3 then gives div_zero = 0 and quot = 3.
- **Held start and ignored start:**
  - Hold ap_start high with din0 = 50 / 5, then change to 60 / 5 at T+3. Required: first result quot = 10, next accept at T+16, second result quot = 12 at T+31.
  - ap_start pulses during CALC cause no extra ap_done.
- **Reset mid-operation:** assert ap_rst at T+6 for one cycle. Required: no ap_done, outputs 0, ap_idle = 1 at T+7. A fresh start at T+8 completes correctly at T+23.
